r5p_hpm: RTL and testbench
==========================

# r5p_hpm

Parametrised hardware performance monitor for the R5P core. It holds the machine cycle counter, the instret counter, a configurable number of programmable `mhpmcounter`/`mhpmevent` pairs and `mcountinhibit`, all with full 64-bit counters on any XLEN. It adds Sscofpmf-style overflow flags and a local counter-overflow interrupt pulse. It sits beside the CSR file: the CSR file forwards Zicsr accesses in the HPM address ranges here and multiplexes `csr_rdt` back when `csr_hit` is set.

## Interface
- `XLEN`, 32, register width; 32 or 64.
- `CNT`, 29, number of implemented programmable counters, 0..29; counter n maps to index 3+n.
- `EVW`, 16, event vector width, 2..XLEN-2.
- `clk`  in  1  clock.
- `rst`  in  1  reset; one clock; reset is asynchronous and active-high.
- `csr_adr`  in  12  CSR address.
- `csr_ren`  in  1  read enable.
- `csr_wen`  in  1  write enable.
- `csr_op`  in  2  01=RW, 10=SET, 11=CLR, 00=no write.
- `csr_msk`  in  XLEN  resolved mask/data (rs1 or zero-extended imm).
- `csr_rdt`  out  XLEN  read data; 0 when `~csr_ren` or `~csr_hit`.
- `csr_hit`  out  1  `csr_adr` is an implemented HPM CSR (combinational).
- `event_i`  in  EVW  event strobes; bit0=cycle, bit1=instret, others generic.
- `lcofi_o`  out  1  one-cycle overflow interrupt pulse.

## Operation
- Address map:
  - `mcountinhibit` 0x320.
  - `mhpmevent3+n` 0x323+n.
  - `mcycle` 0xB00, `minstret` 0xB02, `mhpmcounter3+n` 0xB03+n.
  - XLEN=32 only: high halves at `mcycleh` 0xB80, `minstreth` 0xB82, `mhpmcounter3+nh` 0xB83+n.
  - XLEN=64: 0xB8x is not hit.
  - n >= CNT is not hit; reads return 0, writes are ignored.
- Write value = RW: `msk`; SET: `rdt|msk`; CLR: `rdt&~msk`. `rdt` is the current register value.
- Counters are 64-bit.
  - `mcycle` increments when `event_i[0] & ~CY`.
  - `minstret` increments when `event_i[1] & ~IR`.
  - Counter n increments by exactly 1 when `|(event_i & mhpmevent[n][EVW-1:0]) & ~HPM[3+n]`. Multiple events in one cycle still add 1.
- `mcountinhibit`:
  - Bits 0 (CY), 2 (IR) and 3..3+CNT-1 are writable.
  - Bit 1 and unimplemented bits read 0.
- `mhpmevent[n]`:
  - Bits [EVW-1:0] form the event mask.
  - Bit XLEN-1 is OF (sticky overflow).
  - Other bits read 0.
- Overflow, programmable counters only:
  - Increment from all-ones wraps to 0 and sets OF.
  - If OF was 0, `lcofi_o` pulses the next cycle.
  - If OF was already 1, there is no pulse.
  - `mcycle`/`minstret` wrap silently.
- Software may write OF. Software writes never generate `lcofi_o`.
- Write priority:
  - A write to either half of a counter suppresses that counter's increment in that cycle.
  - The written half takes the new value; the other half holds.
  - A write to `mhpmevent[n]` in the same cycle as an overflow of counter n: the written OF value wins, and the pulse still fires if the hardware set a 0→1 transition.
- Simultaneous overflows of several counters produce one pulse.

## Timing
- Reset values: all counters 0, all `mhpmevent` 0, `mcountinhibit` 0, `lcofi_o` 0.
- `csr_rdt`/`csr_hit` are combinational from `csr_adr` and current state.
- A write is visible on reads from the next cycle.
- An increment is visible on reads the cycle after the event.
- `lcofi_o` is registered: high exactly in cycle k+1 for a wrap at edge k.
- Reset asserted mid-operation clears all state immediately and deasserts `lcofi_o` asynchronously.

## Test plan
- Reset, then read 0xB00/0xB02/0x320 → 0. Drive `event_i[0]` for 10 cycles → `mcycle`=10.
- XLEN=32: write `mcycle`=0xFFFF_FFFF with `event_i[0]`=1 → low=0 and high=1 after one more event. Write-cycle suppression checked: value is 0xFFFF_FFFF the cycle after the write.
- Set `mhpmevent3`=0x0C, drive `event_i`=0x0C for 5 cycles → `mhpmcounter3`=5. Set `mcountinhibit` bit3 → count frozen.
- Preload `mhpmcounter4`=0xFFFF_FFFF_FFFF_FFFF, event on → counter 0, OF=1, `lcofi_o` high exactly 1 cycle. Repeat the wrap with OF still set → no pulse.
- CLR of OF via 0x324 with `csr_msk`=1<<(XLEN-1) → OF=0, `lcofi_o` stays 0. SET op on the event mask ORs the bits correctly.
- CNT=4: access 0xB07/0x327 → `csr_hit`=0, `csr_rdt`=0, writes ignored. Assert `rst` mid-count → all registers 0 immediately.

Source files
------------

// File: rtl/r5p_hpm.sv
// Hardware performance monitor: mcycle, minstret, programmable mhpmcounter/mhpmevent
// pairs with Sscofpmf-style overflow flags, mcountinhibit and a local overflow interrupt.
module r5p_hpm #(
    parameter int XLEN = 32,
    parameter int CNT  = 29,
    parameter int EVW  = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [11:0]     csr_adr,
    input  logic            csr_ren,
    input  logic            csr_wen,
    input  logic [1:0]      csr_op,
    input  logic [XLEN-1:0] csr_msk,
    output logic [XLEN-1:0] csr_rdt,
    output logic            csr_hit,
    input  logic [EVW-1:0]  event_i,
    output logic            lcofi_o
);

    localparam int CA   = (CNT > 0) ? CNT : 1;
    localparam bit RV32 = (XLEN == 32);

    logic [63:0]    cyc_q;
    logic [63:0]    ins_q;
    logic [63:0]    cnt_q [CA];
    logic [EVW-1:0] evm_q [CA];
    logic [CA-1:0]  of_q;
    logic [CA-1:0]  inh_q;
    logic           cy_inh_q;
    logic           ir_inh_q;
    logic           lcofi_q;

    logic           sel_inh, sel_cyc_lo, sel_cyc_hi, sel_ins_lo, sel_ins_hi;
    logic [CA-1:0]  sel_evt, sel_cnt_lo, sel_cnt_hi;
    logic [XLEN-1:0] rdt;
    logic [XLEN-1:0] wdat;
    logic           wr;
    logic [CA-1:0]  inc;
    logic [CA-1:0]  ovf;

    // Address decode; on RV64 the 0xB8x high-half window does not exist.
    always_comb begin
        sel_inh    = (csr_adr == 12'h320);
        sel_cyc_lo = (csr_adr == 12'hB00);
        sel_ins_lo = (csr_adr == 12'hB02);
        sel_cyc_hi = RV32 && (csr_adr == 12'hB80);
        sel_ins_hi = RV32 && (csr_adr == 12'hB82);
        sel_evt    = '0;
        sel_cnt_lo = '0;
        sel_cnt_hi = '0;
        for (int n = 0; n < CNT; n++) begin
            sel_evt[n]    = (csr_adr == 12'h323 + 12'(n));
            sel_cnt_lo[n] = (csr_adr == 12'hB03 + 12'(n));
            sel_cnt_hi[n] = RV32 && (csr_adr == 12'hB83 + 12'(n));
        end
        csr_hit = sel_inh | sel_cyc_lo | sel_cyc_hi | sel_ins_lo | sel_ins_hi
                | (|sel_evt) | (|sel_cnt_lo) | (|sel_cnt_hi);
    end

    always_comb begin
        rdt = '0;
        if (sel_inh) begin
            rdt[0] = cy_inh_q;
            rdt[2] = ir_inh_q;
            for (int n = 0; n < CNT; n++) rdt[3+n] = inh_q[n];
        end
        if (sel_cyc_lo) rdt = cyc_q[XLEN-1:0];
        if (sel_cyc_hi) rdt = XLEN'(cyc_q[63:32]);
        if (sel_ins_lo) rdt = ins_q[XLEN-1:0];
        if (sel_ins_hi) rdt = XLEN'(ins_q[63:32]);
        for (int n = 0; n < CNT; n++) begin
            if (sel_evt[n]) begin
                rdt[EVW-1:0]  = evm_q[n];
                rdt[XLEN-1]   = of_q[n];
            end
            if (sel_cnt_lo[n]) rdt = cnt_q[n][XLEN-1:0];
            if (sel_cnt_hi[n]) rdt = XLEN'(cnt_q[n][63:32]);
        end
    end

    // Access is single-cycle: a read is valid combinationally while csr_ren is high,
    // a write commits at the edge where csr_wen is high and csr_op is non-zero.
    always_comb begin
        case (csr_op)
            2'b10:   wdat = rdt | csr_msk;
            2'b11:   wdat = rdt & ~csr_msk;
            default: wdat = csr_msk;
        endcase
    end

    assign wr      = csr_wen & (csr_op != 2'b00) & csr_hit;
    assign csr_rdt = (csr_ren & csr_hit) ? rdt : '0;
    assign lcofi_o = lcofi_q;

    // A software write to either half of a counter takes precedence over its increment.
    always_comb begin
        inc = '0;
        ovf = '0;
        for (int n = 0; n < CNT; n++) begin
            inc[n] = (|(event_i & evm_q[n])) & ~inh_q[n]
                   & ~(wr & (sel_cnt_lo[n] | sel_cnt_hi[n]));
            ovf[n] = inc[n] & (&cnt_q[n]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc_q    <= '0;
            ins_q    <= '0;
            of_q     <= '0;
            inh_q    <= '0;
            cy_inh_q <= 1'b0;
            ir_inh_q <= 1'b0;
            lcofi_q  <= 1'b0;
            for (int n = 0; n < CA; n++) begin
                cnt_q[n] <= '0;
                evm_q[n] <= '0;
            end
        end else begin
            if (wr & sel_cyc_lo)                 cyc_q[XLEN-1:0] <= wdat;
            else if (wr & sel_cyc_hi)            cyc_q[63:32]    <= wdat[31:0];
            else if (event_i[0] & ~cy_inh_q)     cyc_q           <= cyc_q + 64'd1;

            if (wr & sel_ins_lo)                 ins_q[XLEN-1:0] <= wdat;
            else if (wr & sel_ins_hi)            ins_q[63:32]    <= wdat[31:0];
            else if (event_i[1] & ~ir_inh_q)     ins_q           <= ins_q + 64'd1;

            if (wr & sel_inh) begin
                cy_inh_q <= wdat[0];
                ir_inh_q <= wdat[2];
                for (int n = 0; n < CNT; n++) inh_q[n] <= wdat[3+n];
            end

            for (int n = 0; n < CNT; n++) begin
                if (wr & sel_cnt_lo[n])          cnt_q[n][XLEN-1:0] <= wdat;
                else if (wr & sel_cnt_hi[n])     cnt_q[n][63:32]    <= wdat[31:0];
                else if (inc[n])                 cnt_q[n]           <= cnt_q[n] + 64'd1;

                // Written OF wins over a same-cycle hardware set.
                if (wr & sel_evt[n]) begin
                    evm_q[n] <= wdat[EVW-1:0];
                    of_q[n]  <= wdat[XLEN-1];
                end else if (ovf[n]) begin
                    of_q[n]  <= 1'b1;
                end
            end

            lcofi_q <= |(ovf & ~of_q);
        end
    end

endmodule

// File: tb/tb_r5p_hpm.sv
// Self-checking bench for r5p_hpm (XLEN=32, CNT=4) against a register-image reference model.
`timescale 1ns/1ps
module tb_r5p_hpm;

    localparam int XLEN = 32;
    localparam int CNT  = 4;
    localparam int EVW  = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [11:0]     csr_adr;
    logic            csr_ren;
    logic            csr_wen;
    logic [1:0]      csr_op;
    logic [XLEN-1:0] csr_msk;
    logic [XLEN-1:0] csr_rdt;
    logic            csr_hit;
    logic [EVW-1:0]  event_i;
    logic            lcofi_o;

    always #5 clk = ~clk;

    r5p_hpm #(.XLEN(XLEN), .CNT(CNT), .EVW(EVW)) dut (
        .clk     (clk),
        .rst     (rst),
        .csr_adr (csr_adr),
        .csr_ren (csr_ren),
        .csr_wen (csr_wen),
        .csr_op  (csr_op),
        .csr_msk (csr_msk),
        .csr_rdt (csr_rdt),
        .csr_hit (csr_hit),
        .event_i (event_i),
        .lcofi_o (lcofi_o)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: architectural register images.
    logic [63:0] m_cyc, m_ins;
    logic [63:0] m_cnt [CNT];
    logic [15:0] m_evm [CNT];
    logic        m_of  [CNT];
    logic [31:0] m_inh;
    logic        m_lcofi;

    logic [32:0] exp_q [$];

    logic [11:0] zero_list [17] = '{12'h320, 12'hB00, 12'hB02, 12'hB80, 12'hB82,
                                    12'h323, 12'h324, 12'h325, 12'h326,
                                    12'hB03, 12'hB04, 12'hB05, 12'hB06,
                                    12'hB83, 12'hB84, 12'hB85, 12'hB86};
    logic [11:0] pool [20] = '{12'h320, 12'h323, 12'h324, 12'h325, 12'h326,
                               12'hB00, 12'hB02, 12'hB03, 12'hB04, 12'hB05, 12'hB06,
                               12'hB80, 12'hB82, 12'hB83, 12'hB84, 12'hB85, 12'hB86,
                               12'hB07, 12'h327, 12'hB01};
    logic [11:0] unimpl_list [8] = '{12'hB07, 12'h327, 12'hB87, 12'hB01, 12'h321,
                                     12'h322, 12'hB81, 12'h300};

    task automatic model_reset();
        m_cyc = '0; m_ins = '0; m_inh = '0; m_lcofi = 1'b0;
        for (int n = 0; n < CNT; n++) begin
            m_cnt[n] = '0; m_evm[n] = '0; m_of[n] = 1'b0;
        end
    endtask

    function automatic void model_read(input logic [11:0] adr, output logic [31:0] val,
                                       output logic hit);
        int k;
        val = '0;
        hit = 1'b1;
        k   = 0;
        if (adr == 12'h320) val = m_inh;
        else if (adr == 12'hB00) val = m_cyc[31:0];
        else if (adr == 12'hB80) val = m_cyc[63:32];
        else if (adr == 12'hB02) val = m_ins[31:0];
        else if (adr == 12'hB82) val = m_ins[63:32];
        else if (adr >= 12'h323 && adr < 12'h323 + CNT) begin
            k = int'(adr) - 'h323;
            val = {m_of[k], 15'b0, m_evm[k]};
        end else if (adr >= 12'hB03 && adr < 12'hB03 + CNT) begin
            k = int'(adr) - 'hB03;
            val = m_cnt[k][31:0];
        end else if (adr >= 12'hB83 && adr < 12'hB83 + CNT) begin
            k = int'(adr) - 'hB83;
            val = m_cnt[k][63:32];
        end else hit = 1'b0;
    endfunction

    task automatic model_step(input logic [11:0] adr, input logic wen, input logic [1:0] op,
                              input logic [31:0] msk, input logic [15:0] ev);
        logic [31:0] cur, wv;
        logic        hit, wr, pulse;
        int          k;
        model_read(adr, cur, hit);
        case (op)
            2'b10:   wv = cur | msk;
            2'b11:   wv = cur & ~msk;
            default: wv = msk;
        endcase
        wr    = wen && (op != 2'b00) && hit;
        pulse = 1'b0;
        if (ev[0] && !m_inh[0] && !(wr && (adr == 12'hB00 || adr == 12'hB80))) m_cyc = m_cyc + 1;
        if (ev[1] && !m_inh[2] && !(wr && (adr == 12'hB02 || adr == 12'hB82))) m_ins = m_ins + 1;
        for (int n = 0; n < CNT; n++) begin
            if ((ev & m_evm[n]) != 0 && !m_inh[3+n]
                && !(wr && (int'(adr) == 'hB03 + n || int'(adr) == 'hB83 + n))) begin
                if (m_cnt[n] == 64'hFFFF_FFFF_FFFF_FFFF) begin
                    if (!m_of[n]) pulse = 1'b1;
                    m_of[n] = 1'b1;
                end
                m_cnt[n] = m_cnt[n] + 1;
            end
        end
        if (wr) begin
            if (adr == 12'h320) m_inh = wv & 32'h0000_007D;
            else if (adr == 12'hB00) m_cyc[31:0]  = wv;
            else if (adr == 12'hB80) m_cyc[63:32] = wv;
            else if (adr == 12'hB02) m_ins[31:0]  = wv;
            else if (adr == 12'hB82) m_ins[63:32] = wv;
            else if (adr >= 12'h323 && adr < 12'h323 + CNT) begin
                k = int'(adr) - 'h323;
                m_evm[k] = wv[15:0];
                m_of[k]  = wv[31];
            end else if (adr >= 12'hB03 && adr < 12'hB03 + CNT) begin
                k = int'(adr) - 'hB03;
                m_cnt[k][31:0] = wv;
            end else if (adr >= 12'hB83 && adr < 12'hB83 + CNT) begin
                k = int'(adr) - 'hB83;
                m_cnt[k][63:32] = wv;
            end
        end
        m_lcofi = pulse;
    endtask

    // Drives one clock of stimulus; returns 1ns after the active edge.
    task automatic cycle(input logic [11:0] adr, input logic wen, input logic [1:0] op,
                         input logic [31:0] msk, input logic [15:0] ev);
        csr_adr = adr; csr_ren = 1'b0; csr_wen = wen; csr_op = op; csr_msk = msk; event_i = ev;
        model_step(adr, wen, op, msk, ev);
        @(posedge clk);
        #1;
        csr_wen = 1'b0; csr_op = 2'b00; event_i = '0;
    endtask

    // One idle clock, then present a read address.
    task automatic rd(input logic [11:0] adr);
        cycle(12'h000, 1'b0, 2'b00, 32'h0, 16'h0);
        csr_adr = adr;
        csr_ren = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; csr_adr = '0; csr_ren = 1'b0; csr_wen = 1'b0; csr_op = '0;
        csr_msk = '0; event_i = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        n_cmp++;
        if (lcofi_o !== 1'b0) begin
            n_err++; $display("FAIL reset_lcofi: got %b want 0", lcofi_o);
        end
        for (int i = 0; i < 17; i++) begin
            rd(zero_list[i]);
            n_cmp++;
            if (csr_rdt !== 32'h0 || csr_hit !== 1'b1) begin
                n_err++;
                $display("FAIL reset_read %h: got %h hit %b want 0 hit 1", zero_list[i], csr_rdt, csr_hit);
            end
        end
    endtask

    task automatic test_mcycle();
        repeat (10) cycle(12'h000, 1'b0, 2'b00, 32'h0, 16'h0001);
        rd(12'hB00);
        n_cmp++;
        if (csr_rdt !== 32'd10) begin
            n_err++; $display("FAIL mcycle_10: got %0d want 10", csr_rdt);
        end
        repeat (3) cycle(12'h000, 1'b0, 2'b00, 32'h0, 16'h0003);
        rd(12'hB00);
        n_cmp++;
        if (csr_rdt !== 32'd13) begin
            n_err++; $display("FAIL mcycle_13: got %0d want 13", csr_rdt);
        end
        rd(12'hB02);
        n_cmp++;
        if (csr_rdt !== 32'd3) begin
            n_err++; $display("FAIL minstret_3: got %0d want 3", csr_rdt);
        end
    endtask

    task automatic test_carry();
        cycle(12'hB00, 1'b1, 2'b01, 32'hFFFF_FFFF, 16'h0001);
        rd(12'hB00);
        n_cmp++;
        if (csr_rdt !== 32'hFFFF_FFFF) begin
            n_err++; $display("FAIL mcycle_write_suppress: got %h want ffffffff", csr_rdt);
        end
        cycle(12'h000, 1'b0, 2'b00, 32'h0, 16'h0001);
        rd(12'hB00);
        n_cmp++;
        if (csr_rdt !== 32'h0) begin
            n_err++; $display("FAIL mcycle_carry_lo: got %h want 0", csr_rdt);
        end
        rd(12'hB80);
        n_cmp++;
        if (csr_rdt !== 32'h1) begin
            n_err++; $display("FAIL mcycle_carry_hi: got %h want 1", csr_rdt);
        end
    endtask

    task automatic test_hpm_count();
        cycle(12'h323, 1'b1, 2'b01, 32'h0000_000C, 16'h0);
        repeat (5) cycle(12'h000, 1'b0, 2'b00, 32'h0, 16'h000C);
        rd(12'hB03);
        n_cmp++;
        if (csr_rdt !== 32'd5) begin
            n_err++; $display("FAIL hpm3_count5: got %0d want 5", csr_rdt);
        end
        cycle(12'h000, 1'b0, 2'b00, 32'h0, 16'h0004);
        cycle(12'h000, 1'b0, 2'b00, 32'h0, 16'h0001);
        rd(12'hB03);
        n_cmp++;
        if (csr_rdt !== 32'd6) begin
            n_err++; $display("FAIL hpm3_mask: got %0d want 6", csr_rdt);
        end
        cycle(12'h320, 1'b1, 2'b10, 32'h0000_0008, 16'h0);
        repeat (4) cycle(12'h000, 1'b0, 2'b00, 32'h0, 16'h000C);
        rd(12'hB03);
        n_cmp++;
        if (csr_rdt !== 32'd6) begin
            n_err++; $display("FAIL hpm3_inhibit: got %0d want 6", csr_rdt);
        end
        rd(12'h320);
        n_cmp++;
        if (csr_rdt !== 32'h0000_0008) begin
            n_err++; $display("FAIL inhibit_read: got %h want 00000008", csr_rdt);
        end
        cycle(12'h320, 1'b1, 2'b11, 32'h0000_0008, 16'h0);
    endtask

    task automatic test_overflow();
        cycle(12'h324, 1'b1, 2'b01, 32'h0000_0010, 16'h0);
        for (int rep = 0; rep < 2; rep++) begin
            cycle(12'hB04, 1'b1, 2'b01, 32'hFFFF_FFFF, 16'h0);
            cycle(12'hB84, 1'b1, 2'b01, 32'hFFFF_FFFF, 16'h0);
            cycle(12'h000, 1'b0, 2'b00, 32'h0, 16'h0010);
            n_cmp++;
            if (lcofi_o !== (rep == 0)) begin
                n_err++; $display("FAIL ovf_pulse rep%0d: got %b want %b", rep, lcofi_o, rep == 0);
            end
            cycle(12'h000, 1'b0, 2'b00, 32'h0, 16'h0);
            n_cmp++;
            if (lcofi_o !== 1'b0) begin
                n_err++; $display("FAIL ovf_pulse_end rep%0d: got %b want 0", rep, lcofi_o);
            end
            rd(12'hB04);
            n_cmp++;
            if (csr_rdt !== 32'h0) begin
                n_err++; $display("FAIL ovf_wrap_lo rep%0d: got %h want 0", rep, csr_rdt);
            end
            rd(12'hB84);
            n_cmp++;
            if (csr_rdt !== 32'h0) begin
                n_err++; $display("FAIL ovf_wrap_hi rep%0d: got %h want 0", rep, csr_rdt);
            end
            rd(12'h324);
            n_cmp++;
            if (csr_rdt !== 32'h8000_0010) begin
                n_err++; $display("FAIL ovf_of_set rep%0d: got %h want 80000010", rep, csr_rdt);
            end
        end
    endtask

    task automatic test_of_clear_set();
        cycle(12'h324, 1'b1, 2'b11, 32'h8000_0000, 16'h0);
        n_cmp++;
        if (lcofi_o !== 1'b0) begin
            n_err++; $display("FAIL of_clr_no_pulse: got %b want 0", lcofi_o);
        end
        rd(12'h324);
        n_cmp++;
        if (csr_rdt !== 32'h0000_0010) begin
            n_err++; $display("FAIL of_clr: got %h want 00000010", csr_rdt);
        end
        cycle(12'h324, 1'b1, 2'b10, 32'h0000_0101, 16'h0);
        rd(12'h324);
        n_cmp++;
        if (csr_rdt !== 32'h0000_0111) begin
            n_err++; $display("FAIL evt_set_or: got %h want 00000111", csr_rdt);
        end
        cycle(12'h324, 1'b1, 2'b10, 32'h8000_0000, 16'h0);
        n_cmp++;
        if (lcofi_o !== 1'b0) begin
            n_err++; $display("FAIL of_sw_set_no_pulse: got %b want 0", lcofi_o);
        end
    endtask

    task automatic test_same_cycle();
        cycle(12'h325, 1'b1, 2'b01, 32'h0000_0020, 16'h0);
        cycle(12'h326, 1'b1, 2'b01, 32'h0000_0020, 16'h0);
        cycle(12'hB05, 1'b1, 2'b01, 32'hFFFF_FFFF, 16'h0);
        cycle(12'hB85, 1'b1, 2'b01, 32'hFFFF_FFFF, 16'h0);
        cycle(12'hB06, 1'b1, 2'b01, 32'hFFFF_FFFF, 16'h0);
        cycle(12'hB86, 1'b1, 2'b01, 32'hFFFF_FFFF, 16'h0);
        // Two counters wrap together while counter 5's event register is rewritten with OF=0.
        cycle(12'h325, 1'b1, 2'b01, 32'h0000_0020, 16'h0020);
        n_cmp++;
        if (lcofi_o !== 1'b1) begin
            n_err++; $display("FAIL dual_wrap_pulse: got %b want 1", lcofi_o);
        end
        cycle(12'h000, 1'b0, 2'b00, 32'h0, 16'h0);
        n_cmp++;
        if (lcofi_o !== 1'b0) begin
            n_err++; $display("FAIL dual_wrap_single: got %b want 0", lcofi_o);
        end
        rd(12'h325);
        n_cmp++;
        if (csr_rdt !== 32'h0000_0020) begin
            n_err++; $display("FAIL sw_of_wins: got %h want 00000020", csr_rdt);
        end
        rd(12'h326);
        n_cmp++;
        if (csr_rdt !== 32'h8000_0020) begin
            n_err++; $display("FAIL hw_of_other: got %h want 80000020", csr_rdt);
        end
        cycle(12'hB85, 1'b1, 2'b01, 32'h0000_0005, 16'h0020);
        rd(12'hB05);
        n_cmp++;
        if (csr_rdt !== 32'h0) begin
            n_err++; $display("FAIL hi_write_suppress_lo: got %h want 0", csr_rdt);
        end
        rd(12'hB85);
        n_cmp++;
        if (csr_rdt !== 32'h5) begin
            n_err++; $display("FAIL hi_write_value: got %h want 5", csr_rdt);
        end
    endtask

    task automatic test_unimpl();
        logic [31:0] ev;
        logic        eh;
        for (int i = 0; i < 8; i++) begin
            cycle(unimpl_list[i], 1'b1, 2'b01, 32'hFFFF_FFFF, 16'h0);
            rd(unimpl_list[i]);
            n_cmp++;
            if (csr_rdt !== 32'h0 || csr_hit !== 1'b0) begin
                n_err++;
                $display("FAIL unimpl %h: got %h hit %b want 0 hit 0", unimpl_list[i], csr_rdt, csr_hit);
            end
        end
        for (int n = 0; n < CNT; n++) begin
            rd(12'hB03 + 12'(n));
            model_read(12'hB03 + 12'(n), ev, eh);
            n_cmp++;
            if (csr_rdt !== ev || csr_hit !== eh) begin
                n_err++; $display("FAIL unimpl_no_write cnt%0d: got %h want %h", n, csr_rdt, ev);
            end
        end
        csr_adr = 12'hB00;
        csr_ren = 1'b0;
        #1;
        n_cmp++;
        if (csr_rdt !== 32'h0 || csr_hit !== 1'b1) begin
            n_err++; $display("FAIL ren_low: got %h hit %b want 0 hit 1", csr_rdt, csr_hit);
        end
    endtask

    task automatic test_random();
        logic [11:0] adr;
        logic [31:0] msk, ev;
        logic        eh;
        logic [32:0] exp;
        for (int i = 0; i < 400; i++) begin
            adr = pool[$urandom_range(0, 19)];
            msk = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
            cycle(adr, ($urandom_range(0, 2) == 0), 2'($urandom_range(0, 3)), msk,
                  16'($urandom));
            n_cmp++;
            if (lcofi_o !== m_lcofi) begin
                n_err++; $display("FAIL rand_lcofi it%0d: got %b want %b", i, lcofi_o, m_lcofi);
            end
            adr = pool[$urandom_range(0, 19)];
            csr_adr = adr;
            csr_ren = 1'b1;
            #1;
            model_read(adr, ev, eh);
            exp_q.push_back({eh, ev});
            exp = exp_q.pop_front();
            n_cmp++;
            if ({csr_hit, csr_rdt} !== exp) begin
                n_err++;
                $display("FAIL rand_read it%0d %h: got hit %b %h want hit %b %h", i, adr,
                         csr_hit, csr_rdt, exp[32], exp[31:0]);
            end
        end
    endtask

    task automatic test_reset_mid();
        cycle(12'h320, 1'b1, 2'b01, 32'h0, 16'h0);
        cycle(12'h323, 1'b1, 2'b01, 32'h0000_0001, 16'h0);
        cycle(12'hB03, 1'b1, 2'b01, 32'hFFFF_FFFF, 16'h0);
        cycle(12'hB83, 1'b1, 2'b01, 32'hFFFF_FFFF, 16'h0);
        cycle(12'h000, 1'b0, 2'b00, 32'h0, 16'h0001);
        n_cmp++;
        if (lcofi_o !== 1'b1) begin
            n_err++; $display("FAIL pre_reset_pulse: got %b want 1", lcofi_o);
        end
        #1 rst = 1'b1;
        #1;
        n_cmp++;
        if (lcofi_o !== 1'b0) begin
            n_err++; $display("FAIL async_reset_lcofi: got %b want 0", lcofi_o);
        end
        for (int i = 0; i < 3; i++) begin
            csr_adr = (i == 0) ? 12'hB00 : (i == 1) ? 12'h323 : 12'h320;
            csr_ren = 1'b1;
            #1;
            n_cmp++;
            if (csr_rdt !== 32'h0) begin
                n_err++; $display("FAIL async_reset_read %h: got %h want 0", csr_adr, csr_rdt);
            end
        end
        rst = 1'b0;
        model_reset();
        cycle(12'h000, 1'b0, 2'b00, 32'h0, 16'h0);
    endtask

    initial begin
        test_reset();
        test_mcycle();
        test_carry();
        test_hpm_count();
        test_overflow();
        test_of_clear_set();
        test_same_cycle();
        test_unimpl();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
